// File: rtl/riskhdl_isa_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package  : riskhdl_isa_pkg                                         |
// | Purpose  : riskHDL 16-bit ISA encodings and decoded op ids.        |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
package riskhdl_isa_pkg;

  // Major opcode field instr[15:11]
  localparam logic [4:0] OPC_ALU  = 5'b00000;
  localparam logic [4:0] OPC_LHI  = 5'b00001;
  localparam logic [4:0] OPC_LLI  = 5'b00010;
  localparam logic [4:0] OPC_LDRI = 5'b00011;
  localparam logic [4:0] OPC_LDR  = 5'b00100;
  localparam logic [4:0] OPC_STRI = 5'b00101;
  localparam logic [4:0] OPC_STR  = 5'b00110;
  localparam logic [4:0] OPC_ADDI = 5'b00111;
  localparam logic [4:0] OPC_SUBI = 5'b01000;
  localparam logic [4:0] OPC_MOV  = 5'b01011;
  localparam logic [4:0] OPC_JMP  = 5'b10000;
  localparam logic [4:0] OPC_JALI = 5'b10001;
  localparam logic [4:0] OPC_JAL  = 5'b10010;
  localparam logic [4:0] OPC_JR   = 5'b10011;
  localparam logic [4:0] OPC_SYS  = 5'b11100;

  // Branches are selected on instr[15:12], condition in instr[11:8]
  localparam logic [3:0] BR_PREFIX = 4'b1100;
  localparam logic [3:0] COND_EQ   = 4'b0000;
  localparam logic [3:0] COND_NE   = 4'b0001;
  localparam logic [3:0] COND_CS   = 4'b0010;
  localparam logic [3:0] COND_CC   = 4'b0011;
  localparam logic [3:0] COND_AL   = 4'b1110;

  // Function field instr[1:0]
  localparam logic [1:0] F2_ADD  = 2'b00;
  localparam logic [1:0] F2_ADC  = 2'b01;
  localparam logic [1:0] F2_SUB  = 2'b10;
  localparam logic [1:0] F2_SBB  = 2'b11;
  localparam logic [1:0] F2_STR  = 2'b00;
  localparam logic [1:0] F2_CMP  = 2'b01;
  localparam logic [1:0] F2_OUTR = 2'b00;
  localparam logic [1:0] F2_HLT  = 2'b01;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,  OP_ADC  = 5'd1,  OP_SUB  = 5'd2,  OP_SBB  = 5'd3,
    OP_SUBI = 5'd4,  OP_MOV  = 5'd5,  OP_STRI = 5'd6,  OP_STR  = 5'd7,
    OP_CMP  = 5'd8,  OP_ADDI = 5'd9,  OP_LDR  = 5'd10, OP_LDRI = 5'd11,
    OP_LLI  = 5'd12, OP_LHI  = 5'd13, OP_JMP  = 5'd14, OP_JALI = 5'd15,
    OP_JAL  = 5'd16, OP_JR   = 5'd17, OP_OUTR = 5'd18, OP_HLT  = 5'd19,
    OP_BEQ  = 5'd20, OP_BNE  = 5'd21, OP_BCS  = 5'd22, OP_BCC  = 5'd23,
    OP_BAL  = 5'd24, OP_ILLEGAL = 5'd31
  } op_e;

  // Ops whose target field is a meaningful PC-relative address
  function automatic logic op_is_pcrel(op_e op);
    case (op)
      OP_BEQ, OP_BNE, OP_BCS, OP_BCC, OP_BAL, OP_JMP, OP_JALI: op_is_pcrel = 1'b1;
      default:                                                  op_is_pcrel = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_decode_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Interface : instr_decode_stage_if                                  |
// | Purpose   : fetch-side and register-read-side bundle of the decode |
// |             stage, plus its status outputs.                        |
// | Revision  : 1.0  initial release                                   |
// +--------------------------------------------------------------------+
interface instr_decode_stage_if #(
  parameter int XLEN      = 16,
  parameter int ILL_CNT_W = 8
);
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [15:0]          in_instr;
  logic [XLEN-1:0]      in_pc;
  logic                 out_valid;
  logic                 out_ready;
  logic [4:0]           out_op;
  logic [2:0]           out_rd;
  logic [2:0]           out_rs;
  logic [2:0]           out_rt;
  logic [XLEN-1:0]      out_imm;
  logic [XLEN-1:0]      out_target;
  logic [XLEN-1:0]      out_pc;
  logic                 halted;
  logic [ILL_CNT_W-1:0] ill_cnt;

  // Environment side: supplies words and downstream readiness
  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_op, out_rd, out_rs, out_rt,
           out_imm, out_target, out_pc, halted, ill_cnt
  );

  // Decode stage side
  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_op, out_rd, out_rs, out_rt,
           out_imm, out_target, out_pc, halted, ill_cnt
  );
endinterface
`default_nettype wire

// File: rtl/instr_decode_comb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : instr_decode_comb                                       |
// | Purpose  : pure combinational riskHDL instruction decoder.         |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module instr_decode_comb
  import riskhdl_isa_pkg::*;
#(
  parameter int XLEN = 16
) (
  input  logic [15:0]     instr_i,
  output op_e             op_o,
  output logic [2:0]      rd_o,
  output logic [2:0]      rs_o,
  output logic [2:0]      rt_o,
  output logic [XLEN-1:0] imm_o,
  output logic            is_pcrel_o
);

  logic [4:0] w_opc;
  logic [1:0] w_f2;
  logic [3:0] w_cond;

  assign w_opc  = instr_i[15:11];
  assign w_f2   = instr_i[1:0];
  assign w_cond = instr_i[11:8];

  assign rd_o = instr_i[10:8];
  assign rs_o = instr_i[7:5];
  assign rt_o = instr_i[4:2];

  // Opcode / function / condition to op id
  always_comb begin
    op_o = OP_ILLEGAL;
    if (instr_i[15:12] == BR_PREFIX) begin
      case (w_cond)
        COND_EQ: op_o = OP_BEQ;
        COND_NE: op_o = OP_BNE;
        COND_CS: op_o = OP_BCS;
        COND_CC: op_o = OP_BCC;
        COND_AL: op_o = OP_BAL;
        default: op_o = OP_ILLEGAL;
      endcase
    end else begin
      case (w_opc)
        OPC_ALU: begin
          case (w_f2)
            F2_ADD:  op_o = OP_ADD;
            F2_ADC:  op_o = OP_ADC;
            F2_SUB:  op_o = OP_SUB;
            default: op_o = OP_SBB;
          endcase
        end
        OPC_LHI:  op_o = OP_LHI;
        OPC_LLI:  op_o = OP_LLI;
        OPC_LDRI: op_o = OP_LDRI;
        OPC_LDR:  op_o = OP_LDR;
        OPC_STRI: op_o = OP_STRI;
        OPC_STR: begin
          if (w_f2 == F2_STR)      op_o = OP_STR;
          else if (w_f2 == F2_CMP) op_o = OP_CMP;
          else                     op_o = OP_ILLEGAL;
        end
        OPC_ADDI: op_o = OP_ADDI;
        OPC_SUBI: op_o = OP_SUBI;
        OPC_MOV:  op_o = OP_MOV;
        OPC_JMP:  op_o = OP_JMP;
        OPC_JALI: op_o = OP_JALI;
        OPC_JAL:  op_o = OP_JAL;
        OPC_JR:   op_o = OP_JR;
        OPC_SYS: begin
          if (w_f2 == F2_OUTR)     op_o = OP_OUTR;
          else if (w_f2 == F2_HLT) op_o = OP_HLT;
          else                     op_o = OP_ILLEGAL;
        end
        default:  op_o = OP_ILLEGAL;
      endcase
    end
  end

  // Immediate extraction and extension, keyed on the decoded op
  always_comb begin
    imm_o = '0;
    case (op_o)
      OP_LHI, OP_LLI:
        imm_o = {{(XLEN-8){1'b0}}, instr_i[7:0]};
      OP_LDRI, OP_STRI, OP_ADDI, OP_SUBI:
        imm_o = {{(XLEN-5){1'b0}}, instr_i[4:0]};
      OP_BEQ, OP_BNE, OP_BCS, OP_BCC, OP_BAL:
        imm_o = {{(XLEN-8){instr_i[7]}}, instr_i[7:0]};
      OP_JMP, OP_JALI:
        imm_o = {{(XLEN-11){instr_i[10]}}, instr_i[10:0]};
      default:
        imm_o = '0;
    endcase
  end

  assign is_pcrel_o = op_is_pcrel(op_o);

endmodule
`default_nettype wire

// File: rtl/instr_decode_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : instr_decode_stage                                      |
// | Purpose  : registered valid/ready decode stage with a two-entry    |
// |            skid pipeline, target adder, flush, sticky halt and a   |
// |            saturating illegal-instruction counter.                 |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module instr_decode_stage
  import riskhdl_isa_pkg::*;
#(
  parameter int XLEN      = 16,
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  instr_decode_stage_if.slave  bus
);

  typedef struct packed {
    op_e             op;
    logic [2:0]      rd;
    logic [2:0]      rs;
    logic [2:0]      rt;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc;
  } dec_t;

  op_e             w_op;
  logic [2:0]      w_rd, w_rs, w_rt;
  logic [XLEN-1:0] w_imm;
  logic            w_is_pcrel;
  dec_t            w_new;
  logic            w_in_ready, w_accept, w_out_fire;

  dec_t                 out_q,       out_d;
  logic                 out_valid_q, out_valid_d;
  dec_t                 skid_q,      skid_d;
  logic                 skid_valid_q, skid_valid_d;
  logic                 halted_q,    halted_d;
  logic [ILL_CNT_W-1:0] ill_cnt_q,   ill_cnt_d;

  instr_decode_comb #(.XLEN(XLEN)) u_dec (
    .instr_i    (bus.in_instr),
    .op_o       (w_op),
    .rd_o       (w_rd),
    .rs_o       (w_rs),
    .rt_o       (w_rt),
    .imm_o      (w_imm),
    .is_pcrel_o (w_is_pcrel)
  );

  // Non-PC-relative ops get the fall-through PC so the field is still deterministic
  assign w_new = '{
    op:     w_op,
    rd:     w_rd,
    rs:     w_rs,
    rt:     w_rt,
    imm:    w_imm,
    target: bus.in_pc + XLEN'(1) + (w_is_pcrel ? w_imm : '0),
    pc:     bus.in_pc
  };

  // Ready only from registered state (and reset), never from out_ready
  assign w_in_ready = !skid_valid_q && !halted_q && !rst;
  assign w_accept   = bus.in_valid && w_in_ready && !bus.flush;
  assign w_out_fire = out_valid_q && bus.out_ready;

  // Pipeline, halt and counter next-state
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    halted_d     = halted_q;
    ill_cnt_d    = ill_cnt_q;
    if (bus.flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (!out_valid_q || w_out_fire) begin
        // Output slot frees up: older skid word goes first to keep order
        if (skid_valid_q) begin
          out_d        = skid_q;
          out_valid_d  = 1'b1;
          skid_valid_d = 1'b0;
        end else if (w_accept) begin
          out_d       = w_new;
          out_valid_d = 1'b1;
        end else begin
          out_valid_d = 1'b0;
        end
      end else if (w_accept) begin
        skid_d       = w_new;
        skid_valid_d = 1'b1;
      end
      if (w_accept && (w_op == OP_HLT)) begin
        halted_d = 1'b1;
      end
      if (w_accept && (w_op == OP_ILLEGAL) && (ill_cnt_q != {ILL_CNT_W{1'b1}})) begin
        ill_cnt_d = ill_cnt_q + ILL_CNT_W'(1);
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      halted_q     <= 1'b0;
      ill_cnt_q    <= '0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      halted_q     <= halted_d;
      ill_cnt_q    <= ill_cnt_d;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_op     = out_q.op;
  assign bus.out_rd     = out_q.rd;
  assign bus.out_rs     = out_q.rs;
  assign bus.out_rt     = out_q.rt;
  assign bus.out_imm    = out_q.imm;
  assign bus.out_target = out_q.target;
  assign bus.out_pc     = out_q.pc;
  assign bus.halted     = halted_q;
  assign bus.ill_cnt    = ill_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_decode_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_instr_decode_stage                                   |
// | Purpose  : scoreboard bench for instr_decode_stage.                |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module tb_instr_decode_stage;

  typedef struct {
    logic [4:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [15:0] imm;
    logic [15:0] tgt;
    logic [15:0] pc;
    logic        chk_tgt;
    logic        chk_lat;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  logic lat_mode = 1'b0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instr_decode_stage_if #(.XLEN(16), .ILL_CNT_W(8)) bus  ();
  instr_decode_stage_if #(.XLEN(16), .ILL_CNT_W(2)) bus2 ();

  instr_decode_stage #(.XLEN(16), .ILL_CNT_W(8)) dut  (.clk(clk), .rst(rst), .bus(bus));
  instr_decode_stage #(.XLEN(16), .ILL_CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // Reference decoder written from the ISA table
  function automatic exp_t model(input logic [15:0] w, input logic [15:0] pc);
    exp_t e;
    e.rd = w[10:8]; e.rs = w[7:5]; e.rt = w[4:2];
    e.pc = pc; e.imm = 16'h0; e.op = 5'd31; e.chk_tgt = 1'b0; e.chk_lat = 1'b0; e.cyc = 0;
    if (w[15:12] == 4'hC) begin
      case (w[11:8])
        4'h0: e.op = 5'd20;
        4'h1: e.op = 5'd21;
        4'h2: e.op = 5'd22;
        4'h3: e.op = 5'd23;
        4'hE: e.op = 5'd24;
        default: e.op = 5'd31;
      endcase
      if (e.op != 5'd31) begin
        e.imm = {{8{w[7]}}, w[7:0]};
        e.chk_tgt = 1'b1;
      end
    end else begin
      case (w[15:11])
        5'd0:  e.op = {3'b000, w[1:0]};
        5'd1:  begin e.op = 5'd13; e.imm = {8'h00, w[7:0]}; end
        5'd2:  begin e.op = 5'd12; e.imm = {8'h00, w[7:0]}; end
        5'd3:  begin e.op = 5'd11; e.imm = {11'h000, w[4:0]}; end
        5'd4:  e.op = 5'd10;
        5'd5:  begin e.op = 5'd6;  e.imm = {11'h000, w[4:0]}; end
        5'd6:  e.op = (w[1:0] == 2'b00) ? 5'd7 : (w[1:0] == 2'b01) ? 5'd8 : 5'd31;
        5'd7:  begin e.op = 5'd9;  e.imm = {11'h000, w[4:0]}; end
        5'd8:  begin e.op = 5'd4;  e.imm = {11'h000, w[4:0]}; end
        5'd11: e.op = 5'd5;
        5'd16: begin e.op = 5'd14; e.imm = {{5{w[10]}}, w[10:0]}; e.chk_tgt = 1'b1; end
        5'd17: begin e.op = 5'd15; e.imm = {{5{w[10]}}, w[10:0]}; e.chk_tgt = 1'b1; end
        5'd18: e.op = 5'd16;
        5'd19: e.op = 5'd17;
        5'd28: e.op = (w[1:0] == 2'b00) ? 5'd18 : (w[1:0] == 2'b01) ? 5'd19 : 5'd31;
        default: e.op = 5'd31;
      endcase
    end
    e.tgt = pc + 16'd1 + e.imm;
    e.chk_lat = lat_mode;
    return e;
  endfunction

  function automatic exp_t mk(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs,
                              input logic [2:0] rt, input logic [15:0] imm, input logic [15:0] tgt,
                              input logic [15:0] pc, input logic ct);
    exp_t e;
    e.op = op; e.rd = rd; e.rs = rs; e.rt = rt; e.imm = imm; e.tgt = tgt; e.pc = pc;
    e.chk_tgt = ct; e.chk_lat = lat_mode; e.cyc = 0;
    return e;
  endfunction

  // Output monitor: pops the scoreboard on every transfer out and checks hold stability
  logic        prev_hold = 1'b0;
  logic [68:0] prev_out;
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk_cnt++;
        if ({bus.out_valid, bus.out_op, bus.out_rd, bus.out_rs, bus.out_rt, bus.out_imm,
             bus.out_target, bus.out_pc} !== prev_out)
          $display("FAIL hold_stable got %h required %h",
                   {bus.out_valid, bus.out_op, bus.out_rd, bus.out_rs, bus.out_rt, bus.out_imm,
                    bus.out_target, bus.out_pc}, prev_out);
        else pass_cnt++;
      end
      if (bus.out_valid && bus.out_ready) begin
        chk_cnt++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_out got op=%0d pc=%h required no output", bus.out_op, bus.out_pc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (bus.out_op !== e.op || bus.out_rd !== e.rd || bus.out_rs !== e.rs ||
              bus.out_rt !== e.rt || bus.out_imm !== e.imm || bus.out_pc !== e.pc ||
              (e.chk_tgt && bus.out_target !== e.tgt) || (e.chk_lat && cyc != e.cyc + 1))
            $display("FAIL sb_word got op=%0d rd=%0d rs=%0d rt=%0d imm=%h tgt=%h pc=%h cyc=%0d required op=%0d rd=%0d rs=%0d rt=%0d imm=%h tgt=%h pc=%h cyc=%0d",
                     bus.out_op, bus.out_rd, bus.out_rs, bus.out_rt, bus.out_imm, bus.out_target,
                     bus.out_pc, cyc, e.op, e.rd, e.rs, e.rt, e.imm, e.tgt, e.pc, e.cyc + 1);
          else pass_cnt++;
        end
      end
      prev_hold = bus.out_valid && !bus.out_ready && !bus.flush;
      prev_out  = {bus.out_valid, bus.out_op, bus.out_rd, bus.out_rs, bus.out_rt, bus.out_imm,
                   bus.out_target, bus.out_pc};
    end
  end

  // Offer one word until accepted; entered and left at posedge+1
  task automatic send(input exp_t e, input logic [15:0] w);
    int  n    = 0;
    bit  done = 0;
    bus.in_valid = 1'b1; bus.in_instr = w; bus.in_pc = e.pc;
    while (!done && n < 50) begin
      @(negedge clk);
      if (bus.in_ready && !bus.flush) begin
        e.cyc = cyc;
        sb.push_back(e);
        done = 1;
      end
      @(posedge clk); #1;
      n++;
    end
    bus.in_valid = 1'b0;
    chk_cnt++;
    if (!done) $display("FAIL send_timeout got in_ready=0 for 50 cycles required accept of %h", w);
    else pass_cnt++;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    chk_cnt++;
    if (sb.size() != 0) $display("FAIL drain got %0d pending required 0", sb.size());
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_instr = 16'h0; bus.in_pc = 16'h0; bus.out_ready = 1'b0;
    bus2.flush = 1'b0; bus2.in_valid = 1'b0; bus2.in_instr = 16'h0; bus2.in_pc = 16'h0; bus2.out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk_cnt++;
    if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready got %b required 0", bus.in_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (bus.out_valid !== 1'b0 || bus.halted !== 1'b0 || bus.ill_cnt !== 8'd0)
      $display("FAIL reset_state got v=%b h=%b ill=%0d required 0 0 0", bus.out_valid, bus.halted, bus.ill_cnt);
    else pass_cnt++;
    chk_cnt++;
    if (bus.out_op !== 5'd0 || bus.out_imm !== 16'h0 || bus.out_target !== 16'h0 || bus.out_pc !== 16'h0)
      $display("FAIL reset_data got op=%0d imm=%h tgt=%h pc=%h required zeros", bus.out_op, bus.out_imm, bus.out_target, bus.out_pc);
    else pass_cnt++;
    chk_cnt++;
    if (bus.in_ready !== 1'b1) $display("FAIL post_reset_ready got %b required 1", bus.in_ready);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_decode();
    bus.out_ready = 1'b1;
    lat_mode = 1'b1;
    send(mk(5'd0,  3'd0, 3'd0, 3'd0, 16'h0000, 16'h0011, 16'h0010, 1'b0), 16'h0000);
    send(mk(5'd8,  3'd0, 3'd0, 3'd0, 16'h0000, 16'h0011, 16'h0010, 1'b0), 16'h3001);
    send(mk(5'd12, 3'd0, 3'd5, 3'd1, 16'h00A5, 16'h0000, 16'h0010, 1'b0), 16'h10A5);
    send(mk(5'd21, 3'd1, 3'd7, 3'd7, 16'hFFFE, 16'h000F, 16'h0010, 1'b1), 16'hC1FE);
    send(mk(5'd14, 3'd4, 3'd0, 3'd0, 16'hFC00, 16'hFC11, 16'h0010, 1'b1), 16'h8400);
    send(model(16'h5A6C, 16'h0011), 16'h5A6C);
    send(model(16'h391F, 16'h0012), 16'h391F);
    drain();
    lat_mode = 1'b0;
  endtask

  task automatic test_backpressure();
    int c3 = 0;
    int c4 = 0;
    bus.out_ready = 1'b0;
    fork
      begin
        send(model(16'h0001, 16'h0020), 16'h0001);
        send(model(16'h2345, 16'h0021), 16'h2345);
        send(model(16'h4210, 16'h0022), 16'h4210);
        c3 = cyc;
        send(model(16'h9000, 16'h0023), 16'h9000);
        c4 = cyc;
      end
      begin
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk_cnt++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1)
          $display("FAIL bp_full got in_ready=%b out_valid=%b required 0 1", bus.in_ready, bus.out_valid);
        else pass_cnt++;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    chk_cnt++;
    if (c4 - c3 != 1) $display("FAIL bp_full_rate got %0d cycles between accepts required 1", c4 - c3);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_flush();
    logic [7:0] ic;
    bus.out_ready = 1'b0;
    send(model(16'h5A6C, 16'h0030), 16'h5A6C);
    send(model(16'h391F, 16'h0031), 16'h391F);
    ic = bus.ill_cnt;
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_instr = 16'hF800; bus.in_pc = 16'h0032;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk_cnt++;
    if (bus.out_valid !== 1'b0) $display("FAIL flush_empty got out_valid=%b required 0", bus.out_valid);
    else pass_cnt++;
    chk_cnt++;
    if (bus.ill_cnt !== ic) $display("FAIL flush_ill_cnt got %0d required %0d", bus.ill_cnt, ic);
    else pass_cnt++;
    chk_cnt++;
    if (bus.in_ready !== 1'b1) $display("FAIL flush_ready got %b required 1", bus.in_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_instr = 16'hE001; bus.in_pc = 16'h0033;
    @(negedge clk);
    chk_cnt++;
    if (bus.in_ready !== 1'b1) $display("FAIL flush_not_gating_ready got %b required 1", bus.in_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (bus.halted !== 1'b0 || bus.out_valid !== 1'b0)
      $display("FAIL flush_hlt got halted=%b out_valid=%b required 0 0", bus.halted, bus.out_valid);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    int acc = 0;
    bus.out_ready = 1'b1;
    send(model(16'h3002, 16'h0040), 16'h3002);
    send(model(16'hC500, 16'h0041), 16'hC500);
    send(model(16'hF800, 16'h0042), 16'hF800);
    drain();
    chk_cnt++;
    if (bus.ill_cnt !== 8'd3) $display("FAIL ill_cnt got %0d required 3", bus.ill_cnt);
    else pass_cnt++;
    send(mk(5'd20, 3'd0, 3'd3, 3'd7, 16'h007F, 16'h007F, 16'hFFFF, 1'b1), 16'hC07F);
    send(mk(5'd24, 3'd6, 3'd3, 3'd7, 16'h007F, 16'h007F, 16'hFFFF, 1'b1), 16'hCE7F);
    drain();
    bus2.in_valid = 1'b1; bus2.in_instr = 16'hF800; bus2.in_pc = 16'h0050;
    repeat (5) begin
      @(negedge clk);
      if (bus2.in_ready) acc++;
      @(posedge clk); #1;
    end
    bus2.in_valid = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (acc != 5) $display("FAIL sat_accepts got %0d required 5", acc);
    else pass_cnt++;
    chk_cnt++;
    if (bus2.ill_cnt !== 2'd3 || bus2.out_op !== 5'd31)
      $display("FAIL ill_cnt_sat got cnt=%0d op=%0d required 3 31", bus2.ill_cnt, bus2.out_op);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_halt();
    int rdy = 0;
    bus.out_ready = 1'b1;
    send(model(16'h3905, 16'h0060), 16'h3905);
    send(model(16'hE001, 16'h0061), 16'hE001);
    @(negedge clk);
    chk_cnt++;
    if (bus.halted !== 1'b1 || bus.in_ready !== 1'b0)
      $display("FAIL halt_set got halted=%b in_ready=%b required 1 0", bus.halted, bus.in_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_instr = 16'h5A6C; bus.in_pc = 16'h0062;
    repeat (4) begin
      @(negedge clk);
      if (bus.in_ready) rdy++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk_cnt++;
    if (rdy != 0 || bus.halted !== 1'b1)
      $display("FAIL halt_blocks got ready_cycles=%0d halted=%b required 0 1", rdy, bus.halted);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_mid_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    bus.out_ready = 1'b0;
    send(model(16'hF800, 16'h0070), 16'hF800);
    send(model(16'hE001, 16'h0071), 16'hE001);
    @(negedge clk);
    chk_cnt++;
    if (bus.halted !== 1'b1 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.ill_cnt !== 8'd1)
      $display("FAIL pre_reset got h=%b v=%b rdy=%b ill=%0d required 1 1 0 1", bus.halted, bus.out_valid, bus.in_ready, bus.ill_cnt);
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (bus.in_ready !== 1'b0) $display("FAIL mid_reset_ready got %b required 0", bus.in_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk_cnt++;
    if (bus.out_valid !== 1'b0 || bus.halted !== 1'b0 || bus.ill_cnt !== 8'd0 || bus.in_ready !== 1'b1)
      $display("FAIL mid_reset_state got v=%b h=%b ill=%0d rdy=%b required 0 0 0 1", bus.out_valid, bus.halted, bus.ill_cnt, bus.in_ready);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_decode();
    test_backpressure();
    test_flush();
    test_illegal();
    test_halt();
    test_mid_reset();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
